// File: rtl/sort_sequencer.sv
// Sequential bubble sorter: one adjacent compare/swap per clock over an N-element packed word.
// Optional macro SORT_SEQ_EARLY_EXIT_EN ends the sort after any pass that made no swap.
module sort_sequencer #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 4,
  parameter bit          DESCENDING = 1'b0,
  localparam int unsigned CW        = $clog2(N*(N-1)/2 + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [CW-1:0]  swap_count,
  output logic           busy
);

  localparam int unsigned JW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [N-1:0][W-1:0]    bank, bank_n;
  logic [JW-1:0]          pass, pass_n;
  logic [JW-1:0]          j, j_n, jp1;
  logic [CW-1:0]          cnt, cnt_n;
  logic [W-1:0]           a, b;
  logic                   do_swap;
  logic                   load_out;
`ifdef SORT_SEQ_EARLY_EXIT_EN
  logic                   swapped, swapped_n, swapped_now;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bank_n   = bank;
    pass_n   = pass;
    j_n      = j;
    cnt_n    = cnt;
    load_out = 1'b0;
    in_ready = 1'b0;
    out_valid = 1'b0;
    busy     = 1'b0;
    jp1      = j + JW'(1);
    a        = bank[j];
    b        = bank[jp1];
    do_swap  = DESCENDING ? (a < b) : (a > b);
`ifdef SORT_SEQ_EARLY_EXIT_EN
    swapped_n   = swapped;
    swapped_now = swapped | do_swap;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bank_n  = in_data;
          pass_n  = JW'(N - 1);
          j_n     = '0;
          cnt_n   = '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
          swapped_n = 1'b0;
`endif
          state_n = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (do_swap) begin
          bank_n[j]   = b;
          bank_n[jp1] = a;
          cnt_n       = cnt + CW'(1);
`ifdef SORT_SEQ_EARLY_EXIT_EN
          swapped_n   = 1'b1;
`endif
        end
        if (j == pass - JW'(1)) begin
          // out_data/swap_count capture bank_n so the final pair's swap is included
`ifdef SORT_SEQ_EARLY_EXIT_EN
          if (pass == JW'(1) || !swapped_now) begin
`else
          if (pass == JW'(1)) begin
`endif
            state_n  = DONE;
            load_out = 1'b1;
          end else begin
            pass_n = pass - JW'(1);
            j_n    = '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
            swapped_n = 1'b0;
`endif
          end
        end else begin
          j_n = jp1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
      pass <= '0;
      j    <= '0;
      cnt  <= '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      swapped <= 1'b0;
`endif
    end else begin
      bank <= bank_n;
      pass <= pass_n;
      j    <= j_n;
      cnt  <= cnt_n;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      swapped <= swapped_n;
`endif
    end
  end

  // Result registers are separate from the working bank so they survive the next sort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      swap_count <= '0;
    end else if (load_out) begin
      out_data   <= bank_n;
      swap_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: ascending and descending instances, hand-computed results.
module tb_sort_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;
  logic [2:0]  swap_count;

  logic        in_valid_d = 1'b0, out_ready_d = 1'b0;
  logic [15:0] in_data_d = '0;
  logic        in_ready_d, out_valid_d, busy_d;
  logic [15:0] out_data_d;
  logic [2:0]  swap_count_d;

  int tests = 0;
  int failed = 0;

  sort_sequencer #(.N(4), .W(4), .DESCENDING(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .swap_count(swap_count), .busy(busy)
  );

  sort_sequencer #(.N(4), .W(4), .DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
    .swap_count(swap_count_d), .busy(busy_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers din, then waits for out_valid. Latency counts the accept cycle plus every
  // cycle up to and including the first cycle with out_valid high. out_ready stays low.
  task automatic run_word(input string tag, input logic [15:0] din, input logic [15:0] exp_d,
                          input logic [2:0] exp_c, input int exp_lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_data  = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_count"}, 32'(swap_count), 32'(exp_c));
    if (exp_lat > 0) check({tag, "_latency"}, 32'(n + 1), 32'(exp_lat));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n, nacc, nres;
    logic acc_now;
    logic [15:0] res [0:3];

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1. Reverse order
    run_word("rev", 16'h1234, 16'h4321, 3'd6, 7);
    drain("rev");

    // 2. Already sorted
`ifdef SORT_SEQ_EARLY_EXIT_EN
    run_word("sorted", 16'h4321, 16'h4321, 3'd0, 4);
`else
    run_word("sorted", 16'h4321, 16'h4321, 3'd0, 7);
`endif
    drain("sorted");

    // 3. Duplicates, ascending then descending instance
    run_word("dup", 16'h5A5A, 16'hAA55, 3'd3, 0);

    // 4. Backpressure on the result just produced
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 16'hFFFF;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hAA55);
      check("bp_count", 32'(swap_count), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_retained", 32'(out_data), 32'hAA55);

    n = 0;
    while (!in_ready_d && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_data_d  = 16'h5A5A;
    in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    n = 0;
    while (!out_valid_d && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("desc_out_valid", 32'(out_valid_d), 32'd1);
    check("desc_data", 32'(out_data_d), 32'h55AA);
    check("desc_count", 32'(swap_count_d), 32'd1);
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    out_ready_d = 1'b0;
    check("desc_drained", 32'(out_valid_d), 32'd0);

    // 5. Reset on the third SORT cycle
    in_data  = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    check("mid_count", 32'(swap_count), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_no_output", 32'(out_valid), 32'd0);
    run_word("after_rst", 16'h0F0F, 16'hFF00, 3'd3, 0);
    drain("after_rst");

    // 6. Back-to-back with constant in_valid / out_ready
    out_ready = 1'b1;
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    nacc = 0;
    nres = 0;
    for (int i = 0; i < 40; i++) begin
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        nacc++;
        if (nacc == 1) in_data = 16'h8181;
        else in_valid = 1'b0;
      end
      if (out_valid && nres < 4) begin
        res[nres] = out_data;
        nres++;
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", 32'(nacc), 32'd2);
    check("b2b_results", 32'(nres), 32'd2);
    check("b2b_first", 32'(res[0]), 32'h4321);
    check("b2b_second", 32'(res[1]), 32'h8811);
    check("b2b_last_count", 32'(swap_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
